alu: RTL and testbench

// - 32-bit ARM-style ALU for the execute stage of the single-cycle CPU datapath.
// - Computes ADD, SUB, AND or ORR of SrcA/SrcB, selected by ALUControl.
// - Produces the combinational N/Z/C/V flags consumed by the condition logic.
// - Also holds a registered NZCV snapshot for flag-setting instructions.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/alu_adder.sv | 32 +++
 rtl/alu.sv | 80 ++++++++
 tb/tb_alu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath definitions.
//   alu_op_t  - ALUControl encodings (ADD, SUB, AND, ORR)
//   FLAG_*    - bit positions of N, Z, C and V inside a packed NZCV vector
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// alu_adder: WIDTH-bit adder/subtractor with carry-out and signed overflow.
//   a, b      - operands
//   sub       - 0: a + b, 1: a + ~b + 1 (a - b)
//   sum       - low WIDTH bits of the result, modulo 2^WIDTH
//   carry     - bit WIDTH of the extended sum (ARM not-borrow when subtracting)
//   overflow  - two's-complement signed overflow of the operation
// Outputs are purely combinational.
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;

    // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
    assign b_eff    = sub ? ~b : b;
    assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum   = sum_full[WIDTH-1:0];
    assign carry = sum_full[WIDTH];

    // Overflow when the effective operands share a sign and the result's sign differs.
    assign overflow = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum_full[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// alu: ARM-style execute-stage ALU.
//   clk         - rising-edge clock, used only by the flag register
//   reset       - asynchronous, active-high; clears FlagsQ
//   SrcA, SrcB  - operands
//   ALUControl  - 00 ADD, 01 SUB, 10 AND, 11 ORR
//   FlagWrite   - when 1, FlagsQ captures {N,Z,C,V} on the next rising clk
//   ALUResult   - combinational result
//   Zero        - ALUResult == 0
//   Negative    - ALUResult[WIDTH-1]
//   Overflow    - signed overflow, arithmetic ops only
//   Carry       - carry-out / not-borrow, arithmetic ops only
//   FlagsQ      - registered {N,Z,C,V}
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       ALUControl,
    input  logic             FlagWrite,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             Carry,
    output logic [3:0]       FlagsQ
);

    logic [WIDTH-1:0] sum;
    logic             add_carry;
    logic             add_overflow;
    logic [3:0]       flags_next;

    alu_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (SrcA),
        .b        (SrcB),
        .sub      (ALUControl[0]),
        .sum      (sum),
        .carry    (add_carry),
        .overflow (add_overflow)
    );

    always_comb begin
        ALUResult = sum;
        case (alu_op_t'(ALUControl))
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_ORR: ALUResult = SrcA | SrcB;
            default: ALUResult = sum;
        endcase
    end

    assign Zero     = (ALUResult == '0);
    assign Negative = ALUResult[WIDTH-1];

    // C and V only carry meaning for ADD/SUB; logical ops force them low.
    assign Carry    = ~ALUControl[1] & add_carry;
    assign Overflow = ~ALUControl[1] & add_overflow;

    always_comb begin
        flags_next         = 4'b0000;
        flags_next[FLAG_N] = Negative;
        flags_next[FLAG_Z] = Zero;
        flags_next[FLAG_C] = Carry;
        flags_next[FLAG_V] = Overflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FlagsQ <= 4'b0000;
        end else if (FlagWrite) begin
            FlagsQ <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic [1:0]    ALUControl;
    logic          FlagWrite;
    logic [W-1:0]  ALUResult;
    logic          Zero;
    logic          Negative;
    logic          Overflow;
    logic          Carry;
    logic [3:0]    FlagsQ;

    int vectors;
    int miscompares;

    alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .FlagWrite  (FlagWrite),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Negative   (Negative),
        .Overflow   (Overflow),
        .Carry      (Carry),
        .FlagsQ     (FlagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } vec_t;

    vec_t tbl [12];

    // Reference model: {result, N, Z, C, V} from plain wide arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        longint ua, ub, sa, sb, sres;
        logic [W-1:0] r;
        logic c, v;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'd0: begin
                r    = W'(ua + ub);
                c    = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                sres = sa + sb;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            2'd1: begin
                r    = W'(ua - ub);
                c    = (ua >= ub);
                sres = sa - sb;
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [W-1:0] res, input logic [3:0] nzcv);
        tbl[i].a    = a;
        tbl[i].b    = b;
        tbl[i].op   = op;
        tbl[i].res  = res;
        tbl[i].nzcv = nzcv;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    logic [W+3:0] m;
    logic [3:0]   exp_q;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        FlagWrite   = 1'b0;
        SrcA        = '0;
        SrcB        = '0;
        ALUControl  = 2'b00;

        //            a             b             op     result        NZCV
        set_vec(0,  32'd4,        32'd5,        2'b00, 32'd9,        4'b0000);
        set_vec(1,  32'd4,        32'd5,        2'b01, 32'hFFFF_FFFF, 4'b1000);
        set_vec(2,  32'd4,        32'd5,        2'b10, 32'd4,        4'b0000);
        set_vec(3,  32'd4,        32'd5,        2'b11, 32'd5,        4'b0000);
        set_vec(4,  32'h7FFF_FFFF, 32'd1,       2'b00, 32'h8000_0000, 4'b1001);
        set_vec(5,  32'd5,        32'd5,        2'b01, 32'd0,        4'b0110);
        set_vec(6,  32'hFFFF_FFFF, 32'd1,       2'b00, 32'd0,        4'b0110);
        set_vec(7,  32'h8000_0000, 32'd1,       2'b01, 32'h7FFF_FFFF, 4'b0011);
        set_vec(8,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 32'd0,      4'b0100);
        set_vec(9,  32'h8000_0000, 32'd0,       2'b11, 32'h8000_0000, 4'b1000);
        set_vec(10, 32'd0,        32'd1,        2'b01, 32'hFFFF_FFFF, 4'b1000);
        set_vec(11, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'd0,      4'b0111);

        #1;
        check("reset_flagsq", 64'(FlagsQ), 64'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            SrcA       = tbl[i].a;
            SrcB       = tbl[i].b;
            ALUControl = tbl[i].op;
            #1;
            check($sformatf("table_%0d", i),
                  64'({ALUResult, Negative, Zero, Carry, Overflow}),
                  64'({tbl[i].res, tbl[i].nzcv}));
        end

        // Flag register: load on SUB 5-5, then hold while FlagWrite is low.
        @(negedge clk);
        SrcA = 32'd5; SrcB = 32'd5; ALUControl = 2'b01; FlagWrite = 1'b1;
        @(posedge clk); #1;
        check("flagsq_load", 64'(FlagsQ), 64'h6);
        FlagWrite = 1'b0; SrcA = 32'd4; SrcB = 32'd5; ALUControl = 2'b00;
        @(posedge clk); #1;
        check("flagsq_hold", 64'(FlagsQ), 64'h6);

        // Mid-cycle reset clears FlagsQ without a clock edge; combinational path untouched.
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_reset_flagsq", 64'(FlagsQ), 64'h0);
        check("reset_comb_result", 64'(ALUResult), 64'd9);
        @(negedge clk);
        reset = 1'b0;

        // Randomized ops with random flag writes against the model.
        exp_q = 4'b0000;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            SrcA       = pick_operand();
            SrcB       = ($urandom_range(0, 3) == 0) ? SrcA : pick_operand();
            ALUControl = 2'($urandom_range(0, 3));
            FlagWrite  = 1'($urandom_range(0, 1));
            #1;
            m = model(SrcA, SrcB, ALUControl);
            check($sformatf("rand_comb_%0d", k),
                  64'({ALUResult, Negative, Zero, Carry, Overflow}), 64'(m));
            if (FlagWrite) exp_q = m[3:0];
            @(posedge clk); #1;
            check($sformatf("rand_flagsq_%0d", k), 64'(FlagsQ), 64'(exp_q));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
